ca_run_ctrl: RTL and testbench

CA_RUN_CTRL -- requirements
Module: ca_run_ctrl

---
 rtl/ca_pkg.sv | 14 +
 rtl/ca_step.sv | 23 ++
 rtl/ca_run_ctrl.sv | 116 +++++++++++
 tb/tb_ca_run_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ca_pkg.sv
// Shared types and defaults for the cellular-automaton run controller.
// Holds the FSM state encoding and the default array/counter widths.
package ca_pkg;

  localparam int CA_WIDTH_DEF = 512;
  localparam int CA_CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } ca_state_e;

endpackage

// File: rtl/ca_step.sv
// One combinational generation of an elementary (Wolfram) cellular automaton.
// Cells beyond either end of the array read as 0, so the array does not wrap.
module ca_step #(
  parameter int WIDTH = 512
) (
  input  logic [WIDTH-1:0] q,
  input  logic [7:0]       rule,
  output logic [WIDTH-1:0] next
);

  // Zero guard cell at each end: padded[i+2:i] is {q[i+1], q[i], q[i-1]}.
  logic [WIDTH+1:0] padded;

  assign padded = {1'b0, q, 1'b0};

  always_comb begin
    next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      next[i] = rule[padded[i+2 -: 3]];
    end
  end

endmodule

// File: rtl/ca_run_ctrl.sv
// Runs a Wolfram-rule cellular automaton for a commanded number of generations,
// one generation per cycle, then holds the result until it is consumed.
module ca_run_ctrl
  import ca_pkg::*;
#(
  parameter int WIDTH = CA_WIDTH_DEF,
  parameter int CNT_W = CA_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_rule,
  input  logic [WIDTH-1:0] cmd_seed,
  input  logic [CNT_W-1:0] cmd_gens,
  input  logic             abort,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_state,
  output logic [CNT_W-1:0] res_gens_done,
  output logic             res_aborted,
  output logic             busy,
  output ca_state_e        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; cmd_ready is high only in IDLE, res_valid only in HOLD.

  ca_state_e        state, state_d;
  logic [WIDTH-1:0] cells;
  logic [7:0]       rule_q;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] gens_done;
  logic             aborted;
  logic [WIDTH-1:0] cells_next;
  logic             accept;
  logic             do_step;

  ca_step #(.WIDTH(WIDTH)) u_step (
    .q    (cells),
    .rule (rule_q),
    .next (cells_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    do_step   = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = (cmd_gens == '0) ? ST_HOLD : ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        // Abort wins even over the final generation.
        if (abort) begin
          state_d = ST_HOLD;
        end else begin
          do_step = 1'b1;
          if (remaining == CNT_W'(1)) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells     <= '0;
      rule_q    <= '0;
      remaining <= '0;
      gens_done <= '0;
      aborted   <= 1'b0;
    end else if (accept) begin
      cells     <= cmd_seed;
      rule_q    <= cmd_rule;
      remaining <= cmd_gens;
      gens_done <= '0;
      aborted   <= 1'b0;
    end else if (state == ST_RUN) begin
      if (abort) begin
        aborted <= 1'b1;
      end else if (do_step) begin
        cells     <= cells_next;
        remaining <= remaining - CNT_W'(1);
        gens_done <= gens_done + CNT_W'(1);
      end
    end
  end

  assign res_state     = cells;
  assign res_gens_done = gens_done;
  assign res_aborted   = aborted;
  assign dbg_state     = state;

endmodule

// File: tb/tb_ca_run_ctrl.sv
// Directed bench for ca_run_ctrl: a driver issues commands and queues the
// expected result; a monitor pops and compares on each result handshake.
module tb_ca_run_ctrl;
  import ca_pkg::*;

  localparam int WIDTH = 16;
  localparam int CNT_W = 16;
  localparam int W     = WIDTH + CNT_W + 1;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_rule;
  logic [WIDTH-1:0] cmd_seed;
  logic [CNT_W-1:0] cmd_gens;
  logic             abort;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_state;
  logic [CNT_W-1:0] res_gens_done;
  logic             res_aborted;
  logic             busy;
  ca_state_e        dbg_state;

  logic [W-1:0] exp_q[$];
  int n_tests;
  int n_fail;

  ca_run_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_rule      (cmd_rule),
    .cmd_seed      (cmd_seed),
    .cmd_gens      (cmd_gens),
    .abort         (abort),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_state     (res_state),
    .res_gens_done (res_gens_done),
    .res_aborted   (res_aborted),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(res_state), 64'hdead);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("res_state", 64'(res_state), 64'(e[W-1 -: WIDTH]));
        chk("res_gens_done", 64'(res_gens_done), 64'(e[CNT_W:1]));
        chk("res_aborted", 64'(res_aborted), 64'(e[0]));
      end
    end
  end

  task automatic wait_cmd_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
  endtask

  // abort_at >= 0 raises abort so it is sampled after that many RUN cycles.
  task automatic run_cmd(input logic [7:0] rule, input logic [WIDTH-1:0] seed,
                         input logic [CNT_W-1:0] gens, input int abort_at,
                         input int exp_lat, input logic [WIDTH-1:0] exp_state,
                         input logic [CNT_W-1:0] exp_gens, input logic exp_ab);
    int lat;
    bit seen;
    wait_cmd_ready();
    cmd_rule  = rule;
    cmd_seed  = seed;
    cmd_gens  = gens;
    cmd_valid = 1'b1;
    exp_q.push_back({exp_state, exp_gens, exp_ab});
    lat  = 0;
    seen = 0;
    while (!seen && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) cmd_valid = 1'b0;
      abort = (abort_at >= 0) && (lat == abort_at + 1);
      if (res_valid) seen = 1;
    end
    abort = 1'b0;
    chk("res_valid_seen", 64'(seen), 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    int n;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_rule  = '0;
    cmd_seed  = '0;
    cmd_gens  = '0;
    abort     = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_state", 64'(res_state), 64'd0);
    chk("rst_gens_done", 64'(res_gens_done), 64'd0);
    chk("rst_aborted", 64'(res_aborted), 64'd0);
    chk("rst_fsm", 64'(dbg_state), 64'(ST_IDLE));

    // Rule 110 from a single cell
    run_cmd(8'd110, 16'h0001, 16'd1, -1, 2, 16'h0003, 16'd1, 1'b0);
    run_cmd(8'd110, 16'h0001, 16'd2, -1, 3, 16'h0007, 16'd2, 1'b0);
    run_cmd(8'd110, 16'h0001, 16'd3, -1, 4, 16'h000D, 16'd3, 1'b0);
    // Identity rule, zero generations
    run_cmd(8'd204, 16'h00A5, 16'd0, -1, 1, 16'h00A5, 16'd0, 1'b0);
    // Rule 90 at both edges: no wrap-around
    run_cmd(8'd90, 16'h8001, 16'd1, -1, 2, 16'h4002, 16'd1, 1'b0);
    // Rule 110 at the top edge
    run_cmd(8'd110, 16'h8000, 16'd1, -1, 2, 16'h8000, 16'd1, 1'b0);
    // Abort after three RUN cycles of a long run
    run_cmd(8'd110, 16'h0001, 16'd100, 3, 5, 16'h000D, 16'd3, 1'b1);
    // Abort on the final-generation cycle wins
    run_cmd(8'd110, 16'h0001, 16'd2, 1, 3, 16'h0003, 16'd1, 1'b1);
    // Abort in IDLE is ignored
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_fsm", 64'(dbg_state), 64'(ST_IDLE));
    run_cmd(8'd110, 16'h0001, 16'd1, -1, 2, 16'h0003, 16'd1, 1'b0);

    // Stalled result: outputs hold, second command waits for the handshake
    wait_cmd_ready();
    res_ready = 1'b0;
    cmd_rule  = 8'd110;
    cmd_seed  = 16'h0001;
    cmd_gens  = 16'd2;
    cmd_valid = 1'b1;
    exp_q.push_back({16'h0007, 16'd2, 1'b0});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_res_valid", 64'(res_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_state", 64'(res_state), 64'h7);
      chk("stall_gens", 64'(res_gens_done), 64'd2);
      chk("stall_cmd_ready", 64'(cmd_ready), 64'd0);
      if (i == 0) begin
        cmd_rule  = 8'd204;
        cmd_seed  = 16'h003C;
        cmd_gens  = 16'd0;
        cmd_valid = 1'b1;
        exp_q.push_back({16'h003C, 16'd0, 1'b0});
      end
      @(posedge clk);
      #1;
      chk("stall_fsm_hold", 64'(dbg_state), 64'(ST_HOLD));
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_fsm_idle", 64'(dbg_state), 64'(ST_IDLE));
    chk("hs_res_valid", 64'(res_valid), 64'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("second_cmd_hold", 64'(res_valid), 64'd1);
    chk("second_cmd_state", 64'(res_state), 64'h3C);
    @(negedge clk);

    // Reset in the middle of a run
    wait_cmd_ready();
    cmd_rule  = 8'd110;
    cmd_seed  = 16'h0001;
    cmd_gens  = 16'd100;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fsm", 64'(dbg_state), 64'(ST_IDLE));
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_state", 64'(res_state), 64'd0);
    chk("mid_rst_gens", 64'(res_gens_done), 64'd0);
    chk("mid_rst_aborted", 64'(res_aborted), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(8'd110, 16'h0001, 16'd3, -1, 4, 16'h000D, 16'd3, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
